// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit multiply/divide unit with HI/LO registers for
// the E stage of a 5-stage MIPS pipeline. Multiplies use shift-add and divides
// use restoring division, one bit per clock, on operand magnitudes. The sign
// fixup is applied at writeback.
// Optional build macro MULDIV_FAST_MUL_EN: MULT/MULTU use a single-cycle
// combinational multiplier and write HI/LO at the start edge. Divides are
// unaffected by this macro.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startE,
  input  logic [1:0]       opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             cancelE,
  input  logic             readhiloD,
  input  logic             wehiE,
  input  logic             weloE,
  input  logic [WIDTH-1:0] wdE,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stallreq
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t             state_q;
  logic [CNTW-1:0]    cnt_q;
  // Upper WIDTH+1 bits hold the partial product or remainder.
  // Lower WIDTH bits hold the multiplier or the dividend/quotient.
  logic [2*WIDTH:0]   acc_q;
  logic [2*WIDTH:0]   acc_d;
  logic [WIDTH:0]     opnd_q;     // multiplicand or divisor magnitude
  logic               is_div_q;
  logic               resneg_q;   // negate product / quotient at writeback
  logic               remneg_q;   // remainder takes the dividend's sign
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               busy_q;

  logic               a_neg_s, b_neg_s, b_zero_s;
  logic [WIDTH:0]     a_mag_s, b_mag_s;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     shifted_s;
  logic [WIDTH+1:0]   diff_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;
  logic [WIDTH-1:0]   hi_fin_s, lo_fin_s;
  logic               fast_sel_s;
  logic [2*WIDTH-1:0] fast_prod_s;
  logic [WIDTH-1:0]   fast_hi_s, fast_lo_s;

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign stallreq = busy_q & (startE | readhiloD | wehiE | weloE);

  // Operand signs and WIDTH+1-bit magnitudes; opE[0] set means unsigned
  always_comb begin
    a_neg_s  = ~opE[0] & srcaE[WIDTH-1];
    b_neg_s  = ~opE[0] & srcbE[WIDTH-1];
    b_zero_s = (srcbE == {WIDTH{1'b0}});
    if (a_neg_s) begin
      a_mag_s = {(WIDTH+1){1'b0}} - {srcaE[WIDTH-1], srcaE};
    end else begin
      a_mag_s = {1'b0, srcaE};
    end
    if (b_neg_s) begin
      b_mag_s = {(WIDTH+1){1'b0}} - {srcbE[WIDTH-1], srcbE};
    end else begin
      b_mag_s = {1'b0, srcbE};
    end
  end

  // Single-cycle multiply path; it is only selected when the macro is defined
  always_comb begin
    fast_prod_s = {(2*WIDTH){1'b0}};
    fast_hi_s   = {WIDTH{1'b0}};
    fast_lo_s   = {WIDTH{1'b0}};
    fast_sel_s  = 1'b0;
`ifdef MULDIV_FAST_MUL_EN
    fast_sel_s  = ~opE[1];
    fast_prod_s = {{WIDTH{1'b0}}, a_mag_s[WIDTH-1:0]} * {{WIDTH{1'b0}}, b_mag_s[WIDTH-1:0]};
    if (a_neg_s ^ b_neg_s) begin
      fast_prod_s = {(2*WIDTH){1'b0}} - fast_prod_s;
    end else begin
      fast_prod_s = fast_prod_s;
    end
    fast_hi_s   = fast_prod_s[2*WIDTH-1:WIDTH];
    fast_lo_s   = fast_prod_s[WIDTH-1:0];
`else
    fast_sel_s  = 1'b0;
`endif
  end

  // One shift-add or restoring-divide iteration, plus the sign-fixed final results
  always_comb begin
    sum_s     = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? opnd_q : {(WIDTH+1){1'b0}});
    shifted_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff_s    = {1'b0, shifted_s} - {1'b0, opnd_q};
    if (is_div_q) begin
      if (!diff_s[WIDTH+1]) begin
        acc_d = {diff_s[WIDTH:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = {shifted_s, acc_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_d = {sum_s, acc_q[WIDTH-1:0]} >> 1;
    end
    prod_s = acc_d[2*WIDTH-1:0];
    quo_s  = acc_d[WIDTH-1:0];
    rem_s  = acc_d[2*WIDTH-1:WIDTH];
    if (resneg_q) begin
      prod_s = {(2*WIDTH){1'b0}} - prod_s;
      quo_s  = {WIDTH{1'b0}} - quo_s;
    end else begin
      prod_s = prod_s;
      quo_s  = quo_s;
    end
    if (remneg_q) begin
      rem_s = {WIDTH{1'b0}} - rem_s;
    end else begin
      rem_s = rem_s;
    end
    if (is_div_q) begin
      hi_fin_s = rem_s;
      lo_fin_s = quo_s;
    end else begin
      hi_fin_s = prod_s[2*WIDTH-1:WIDTH];
      lo_fin_s = prod_s[WIDTH-1:0];
    end
  end

  // Control FSM: accepts operations, iterates, writes HI/LO and handles MTHI/MTLO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CNTW{1'b0}};
      acc_q    <= {(2*WIDTH+1){1'b0}};
      opnd_q   <= {(WIDTH+1){1'b0}};
      is_div_q <= 1'b0;
      resneg_q <= 1'b0;
      remneg_q <= 1'b0;
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (startE && !cancelE) begin
            // start wins over a same-cycle MTHI/MTLO
            if (fast_sel_s) begin
              hi_q <= fast_hi_s;
              lo_q <= fast_lo_s;
            end else begin
              acc_q    <= {{WIDTH{1'b0}}, a_mag_s};
              opnd_q   <= b_mag_s;
              is_div_q <= opE[1];
              // divide by zero keeps an all-ones quotient, so no negation
              resneg_q <= (a_neg_s ^ b_neg_s) & ~(opE[1] & b_zero_s);
              remneg_q <= a_neg_s;
              cnt_q    <= {CNTW{1'b0}};
              busy_q   <= 1'b1;
              state_q  <= S_RUN;
            end
          end else begin
            if (wehiE) hi_q <= wdE;
            if (weloE) lo_q <= wdE;
          end
        end
        S_RUN: begin
          if (cancelE) begin
            cnt_q   <= {CNTW{1'b0}};
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
            if (cnt_q == CNTW'(WIDTH-1)) begin
              hi_q    <= hi_fin_s;
              lo_q    <= lo_fin_s;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
